usb_packet_tx: RTL and testbench
================================

Name: usb_packet_tx

Overview:
USB LS/FS packet transmitter. It serialises a PID and an optional byte stream onto D+/D- with:
- SYNC generation
- NRZI encoding
- bit stuffing
- EOP generation

It is the transmit counterpart of the proxy's packet receiver. It is used to inject packets toward host or device (e.g. synthetic keyboard reports), and the proxy muxes its dp/dm/oe onto the GPIO pads.

Parameters:
LS_DIV, 33, clk cycles per bit at low speed (50 MHz / 1.5 Mbit/s, truncated)
FS_DIV, 4, clk cycles per bit at full speed (50 MHz / 12 Mbit/s, truncated)

Ports:
clk  input  1  system clock (MAX10_CLK1_50 domain)
rst  input  1  synchronous active-high reset
is_fs  input  1  1 = full speed, 0 = low speed; sampled only when start is accepted
start  input  1  request a packet; accepted only when busy = 0
pid  input  4  PID code; transmitted PID byte = {~pid, pid}
has_data  input  1  1 = data bytes follow the PID; 0 = PID-only (token body supplied as data, handshake)
data  input  8  payload byte, sent LSB first
data_valid  input  1  payload byte available
data_last  input  1  marks the final payload byte (qualified by data_valid)
data_ready  output  1  1-cycle pulse: byte on data accepted into the shifter
dp_out  output  1  D+ drive value
dm_out  output  1  D- drive value
oe  output  1  pad output enable
busy  output  1  high from start acceptance through the end of EOP
done  output  1  1-cycle pulse on the cycle busy falls
underrun  output  1  1-cycle pulse when a byte was needed but data_valid = 0

Behaviour:
- Reset values: oe = 0, busy = 0, done = 0, data_ready = 0, underrun = 0, and dp/dm at idle J for the current is_fs.
  - Idle J: FS is dp = 1, dm = 0; LS is dp = 0, dm = 1.
  - Reset mid-packet takes effect on the next edge: the line is released immediately and no EOP is sent.
- Bit timer:
  - Counts DIV = is_fs ? FS_DIV : LS_DIV clocks per bit; it is cleared on start.
  - Each line state is held for exactly DIV cycles.
  - The first SYNC bit appears on the cycle after start is sampled, with oe = 1 and busy = 1 from that cycle.
- FSM states: IDLE, SYNC, PID, DATA, [CRC], EOP_SE0, EOP_J, then back to IDLE.
  - SYNC: 8 raw bits 0000_0001. On the line this is K J K J K J K K, with NRZI starting from J.
  - PID: 8 bits of {~pid, pid}, LSB first.
  - At the end of PID: if has_data, go to DATA; otherwise go to EOP_SE0.
  - DATA:
    - The next byte is sampled on the clock at which the previous byte's last bit period ends (the bit-strobe cycle).
    - If data_valid, the byte is loaded and data_ready pulses.
    - If data_valid = 0, underrun pulses and the FSM proceeds as if data_last had been seen.
    - After the byte flagged data_last, the FSM goes to CRC (if enabled) or to EOP_SE0.
  - EOP: SE0 (dp = dm = 0) for 2 bit times, then J for 1 bit time. oe drops and done pulses on the cycle after EOP_J ends.
- NRZI: a raw 0 toggles J/K; a raw 1 holds the line.
- Bit stuffing:
  - A ones counter runs from the SYNC field onward; the final SYNC 1 counts.
  - After 6 consecutive raw 1s, a 0 is inserted and the counter clears. Any 0 also clears the counter.
  - Stuff bits are inserted before EOP as well, when the 6th 1 is the last data bit.
  - Stuffing applies in PID, DATA and CRC. It never applies in EOP.
- Inputs are ignored while they are not being sampled. A start pulse during busy is dropped.

Optional Feature:
USB_TX_CRC16_EN defined:
- When has_data = 1, a CRC16 (polynomial 0x8005, seed 0xFFFF) is computed over all accepted payload bytes.
- The complemented CRC is appended, 16 bits LSB first, in state CRC, and is bit-stuffed.
- A zero-payload data packet (has_data = 1 with the first byte underrun and no byte accepted, so underrun pulses) sends CRC 0x0000.

Undefined:
- The CRC state is absent; the caller supplies CRC bytes as payload.

Test Plan:
- FS_DIV = 4, is_fs = 1, start with pid = 4'h2 (ACK), has_data = 0.
  - Line sequence is KJKJKJKK then JJKJJKKK then SE0 SE0 J.
  - oe is high for 19 × 4 = 76 cycles, done pulses once, and data_ready never pulses.
- LS, pid = 4'h3, has_data = 1, one byte 0xFF with last, CRC disabled.
  - PID 0xC3 ends 1,1, so a stuff 0 is inserted after the 4th data bit.
  - Payload occupies 9 bit times (297 clk) and data_ready pulses exactly once.
- USB_TX_CRC16_EN, FS, pid = 4'hB, has_data = 1, data_valid = 0 (zero-length packet).
  - underrun pulses; 16 zero bits follow the PID (alternating J/K, no stuffing), then EOP.
- Back-pressure: data_valid drops before the 2nd byte of a 3-byte packet.
  - underrun pulses at that byte slot and EOP follows the 1st byte.
- rst asserted in the middle of DATA.
  - The next cycle shows oe = 0 and busy = 0 with no done pulse.
  - A new start is then accepted and produces an ACK packet identical to test 1.
- start re-pulsed while busy.
  - It is ignored: exactly one packet and one done pulse are produced.

Source files
------------

// File: rtl/usb_packet_tx.sv
// USB LS/FS packet transmitter: SYNC, PID, payload (+CRC16 when USB_TX_CRC16_EN), NRZI, bit stuffing, EOP.
// Latency: first SYNC bit drives the line the cycle after start is accepted; each line state lasts DIV clocks.
// Backpressure: one byte sampled per bit-strobe at byte boundaries; data_valid low there pulses underrun and ends the payload.
module usb_packet_tx #(
    parameter int LS_DIV = 33,
    parameter int FS_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_fs,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic       has_data,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
`ifdef USB_TX_CRC16_EN
        S_CRC,
`endif
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t      state_q, state_n;
    logic        fs_q, fs_n;
    logic [3:0]  pid_q, pid_n;
    logic        has_q, has_n;
    logic        last_q, last_n;
    logic [5:0]  cnt_q, cnt_n;
    logic [3:0]  idx_q, idx_n;
    logic [15:0] shreg_q, shreg_n;
    logic [2:0]  ones_q, ones_n;
    logic        lvl_q, lvl_n;     // 1 = J, 0 = K
    logic        done_n, rdy_n, und_n;
    logic [5:0]  div_m1;
    logic        strobe, serial, need_byte, spd;
    logic        send, nb, tail, go_eop;
    logic [3:0]  end_idx;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_n;

    // Reflected form of poly 0x8005, matching LSB-first bit order on the wire.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign div_m1    = fs_q ? 6'(FS_DIV - 1) : 6'(LS_DIV - 1);
    assign strobe    = (cnt_q == div_m1);
    assign busy      = (state_q != S_IDLE);
    assign oe        = busy;
    assign spd       = busy ? fs_q : is_fs;
    assign need_byte = (state_q == S_PID && has_q) || (state_q == S_DATA && !last_q);
`ifdef USB_TX_CRC16_EN
    assign serial    = state_q inside {S_SYNC, S_PID, S_DATA, S_CRC};
    assign end_idx   = (state_q == S_CRC) ? 4'd15 : 4'd7;
`else
    assign serial    = state_q inside {S_SYNC, S_PID, S_DATA};
    assign end_idx   = 4'd7;
`endif

    always_comb begin
        state_n = state_q;
        fs_n    = fs_q;
        pid_n   = pid_q;
        has_n   = has_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;
        ones_n  = ones_q;
        lvl_n   = lvl_q;
`ifdef USB_TX_CRC16_EN
        crc_n   = crc_q;
`endif
        done_n  = 1'b0;
        rdy_n   = 1'b0;
        und_n   = 1'b0;
        send    = 1'b0;
        nb      = 1'b0;
        tail    = 1'b0;
        go_eop  = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                state_n = S_SYNC;
                fs_n    = is_fs;
                pid_n   = pid;
                has_n   = has_data;
                last_n  = 1'b0;
                cnt_n   = '0;
                idx_n   = '0;
                shreg_n = 16'h0080;
                ones_n  = '0;
                lvl_n   = 1'b0;    // first raw 0 toggles idle J to K
`ifdef USB_TX_CRC16_EN
                crc_n   = 16'hFFFF;
`endif
            end
        end else begin
            cnt_n = strobe ? '0 : cnt_q + 6'd1;
            if (strobe) begin
                if (serial && ones_q == 3'd6) begin
                    send = 1'b1;   // stuffed 0, bit position does not advance
                end else if (serial && idx_q != end_idx) begin
                    shreg_n = shreg_q >> 1;
                    idx_n   = idx_q + 4'd1;
                    send    = 1'b1;
                    nb      = shreg_q[1];
                end else if (state_q == S_SYNC) begin
                    state_n = S_PID;
                    shreg_n = {8'h00, ~pid_q, pid_q};
                    idx_n   = '0;
                    send    = 1'b1;
                    nb      = pid_q[0];
                end else if (need_byte) begin
                    if (data_valid) begin
                        state_n = S_DATA;
                        shreg_n = {8'h00, data};
                        idx_n   = '0;
                        last_n  = data_last;
                        rdy_n   = 1'b1;
                        send    = 1'b1;
                        nb      = data[0];
`ifdef USB_TX_CRC16_EN
                        crc_n   = crc16_byte(crc_q, data);
`endif
                    end else begin
                        und_n = 1'b1;
                        tail  = 1'b1;
                    end
                end else if (state_q == S_PID || state_q == S_DATA) begin
                    tail = 1'b1;
                end else if (state_q == S_EOP_SE0) begin
                    if (idx_q == 4'd1) begin
                        state_n = S_EOP_J;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_q + 4'd1;
                    end
                end else if (state_q == S_EOP_J) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    go_eop = 1'b1;
                end
            end
        end

        if (tail) begin
`ifdef USB_TX_CRC16_EN
            if (has_q) begin
                state_n = S_CRC;
                shreg_n = ~crc_q;
                idx_n   = '0;
                send    = 1'b1;
                nb      = ~crc_q[0];
            end else begin
                go_eop = 1'b1;
            end
`else
            go_eop = 1'b1;
`endif
        end

        if (go_eop) begin
            state_n = S_EOP_SE0;
            idx_n   = '0;
        end

        if (send) begin
            ones_n = nb ? ones_q + 3'd1 : 3'd0;
            lvl_n  = nb ? lvl_q : ~lvl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fs_q       <= 1'b0;
            pid_q      <= '0;
            has_q      <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            ones_q     <= '0;
            lvl_q      <= 1'b1;
`ifdef USB_TX_CRC16_EN
            crc_q      <= 16'hFFFF;
`endif
            done       <= 1'b0;
            data_ready <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_n;
            fs_q       <= fs_n;
            pid_q      <= pid_n;
            has_q      <= has_n;
            last_q     <= last_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            shreg_q    <= shreg_n;
            ones_q     <= ones_n;
            lvl_q      <= lvl_n;
`ifdef USB_TX_CRC16_EN
            crc_q      <= crc_n;
`endif
            done       <= done_n;
            data_ready <= rdy_n;
            underrun   <= und_n;
        end
    end

    always_comb begin
        dp_out = spd;
        dm_out = ~spd;
        if (state_q == S_EOP_SE0) begin
            dp_out = 1'b0;
            dm_out = 1'b0;
        end else if (serial) begin
            dp_out = ~(lvl_q ^ spd);
            dm_out = lvl_q ^ spd;
        end
    end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed bench for usb_packet_tx: line symbols per cycle, handshake pulse counts, reset and start-while-busy.
module tb_usb_packet_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_fs;
    logic       start;
    logic [3:0] pid;
    logic       has_data;
    logic [7:0] data;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic       dp_out;
    logic       dm_out;
    logic       oe;
    logic       busy;
    logic       done;
    logic       underrun;

    always #10 clk = ~clk;

    usb_packet_tx #(.LS_DIV(33), .FS_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_fs      (is_fs),
        .start      (start),
        .pid        (pid),
        .has_data   (has_data),
        .data       (data),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .dp_out     (dp_out),
        .dm_out     (dm_out),
        .oe         (oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [1:0] line_q[$];
    int         done_cnt = 0;
    int         rdy_cnt  = 0;
    int         und_cnt  = 0;
    logic       clr_mon  = 1'b0;

    always @(negedge clk) begin
        if (clr_mon) begin
            line_q.delete();
            done_cnt = 0;
            rdy_cnt  = 0;
            und_cnt  = 0;
        end else begin
            if (oe === 1'b1) line_q.push_back({dp_out, dm_out});
            if (done === 1'b1) done_cnt++;
            if (data_ready === 1'b1) rdy_cnt++;
            if (underrun === 1'b1) und_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sym_code(input byte c, input logic fs);
        case (c)
            "J":     return fs ? 2'b10 : 2'b01;
            "K":     return fs ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // exp: one character per bit time (J, K, 0 = SE0); each must last div cycles.
    task automatic check_line(input string tag, input string exp, input logic fs, input int div);
        int bad;
        int total;
        bad   = -1;
        total = exp.len() * div;
        check({tag, " oe cycles"}, line_q.size(), total);
        for (int i = 0; i < line_q.size() && i < total; i++)
            if (bad < 0 && line_q[i] !== sym_code(exp[i / div], fs)) bad = i;
        check({tag, " first bad line cycle"}, bad, -1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done within budget"}, {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " data_ready within budget"}, {31'd0, data_ready}, 32'd1);
    endtask

    task automatic start_pkt();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr_mon = 1'b1;
        repeat (2) @(negedge clk);
        clr_mon = 1'b0;
    endtask

    localparam string ACK_LINE = "KJKJKJKKJJKJJKKK00J";

    initial begin
        rst = 1'b1; is_fs = 1'b1; start = 1'b0; pid = 4'h0; has_data = 1'b0;
        data = 8'h00; data_valid = 1'b0; data_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset oe", {31'd0, oe}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset data_ready", {31'd0, data_ready}, 32'd0);
        check("reset underrun", {31'd0, underrun}, 32'd0);
        check("reset FS idle J", {30'd0, dp_out, dm_out}, 32'd2);
        rst = 1'b0;
        @(negedge clk);
        is_fs = 1'b0;
        #1;
        check("idle LS J", {30'd0, dp_out, dm_out}, 32'd1);
        is_fs = 1'b1;

        // FS ACK, PID only
        clear_mon();
        pid = 4'h2; has_data = 1'b0;
        start_pkt();
        wait_done("ack", 500);
        check_line("ack", ACK_LINE, 1'b1, 4);
        check("ack done pulses", done_cnt, 1);
        check("ack data_ready pulses", rdy_cnt, 0);

        // LS, one 0xFF byte: stuff bit after 4th payload bit
        clear_mon();
        is_fs = 1'b0; pid = 4'h3; has_data = 1'b1;
        data = 8'hFF; data_valid = 1'b1; data_last = 1'b1;
        start_pkt();
        wait_done("ls ff", 3000);
        check_line("ls ff", "KJKJKJKKKKJKJKKKKKKKJJJJJ00J", 1'b0, 33);
        check("ls ff data_ready pulses", rdy_cnt, 1);
        check("ls ff underrun pulses", und_cnt, 0);
        data_valid = 1'b0; data_last = 1'b0;

`ifdef USB_TX_CRC16_EN
        // FS zero-length DATA1: underrun then complemented seed = 16 zero bits
        clear_mon();
        is_fs = 1'b1; pid = 4'hB; has_data = 1'b1; data_valid = 1'b0;
        start_pkt();
        wait_done("zlp", 1000);
        check_line("zlp", "KJKJKJKKKKJJKJJKJKJKJKJKJKJKJKJK00J", 1'b1, 4);
        check("zlp underrun pulses", und_cnt, 1);
        check("zlp data_ready pulses", rdy_cnt, 0);
`else
        // FS, 3-byte packet starved at byte 2
        clear_mon();
        is_fs = 1'b1; pid = 4'h3; has_data = 1'b1;
        data = 8'h00; data_valid = 1'b1; data_last = 1'b0;
        start_pkt();
        wait_ready("starve", 500);
        data_valid = 1'b0;
        wait_done("starve", 1000);
        check_line("starve", "KJKJKJKKKKJKJKKKJKJKJKJK00J", 1'b1, 4);
        check("starve underrun pulses", und_cnt, 1);
        check("starve data_ready pulses", rdy_cnt, 1);
        check("starve done pulses", done_cnt, 1);
`endif

        // Reset in the middle of DATA
        clear_mon();
        is_fs = 1'b0; pid = 4'h3; has_data = 1'b1;
        data = 8'hFF; data_valid = 1'b1; data_last = 1'b0;
        start_pkt();
        wait_ready("mid rst", 2000);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst oe", {31'd0, oe}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        rst = 1'b0; data_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid rst no done pulse", done_cnt, 0);

        clear_mon();
        is_fs = 1'b1; pid = 4'h2; has_data = 1'b0;
        start_pkt();
        wait_done("ack after rst", 500);
        check_line("ack after rst", ACK_LINE, 1'b1, 4);
        check("ack after rst done pulses", done_cnt, 1);

        // start re-pulsed while busy
        clear_mon();
        start_pkt();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 500);
        repeat (100) @(negedge clk);
        check_line("restart", ACK_LINE, 1'b1, 4);
        check("restart done pulses", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
